frame_timing_gen: RTL and testbench

Parametrised PPS-disciplined radio frame timing generator. It produces sample, symbol, slot and frame counters plus per-channel symbol-gated triggers for the TX/RX datapaths. It supports configurable numerology, two long-CP symbol positions per slot, and per-channel, per-symbol TDD masks. It keeps running between PPS edges and checks each PPS alignment event against the running count, realigning and flagging on mismatch.

---
 rtl/frame_timing_gen.sv | 156 +++++++++++++++
 tb/tb_frame_timing_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_timing_gen.sv
// PPS-disciplined radio frame timing generator: sample/symbol/slot/frame counters,
// alignment checking against a delayed PPS event, and per-channel symbol-gated triggers.
module frame_timing_gen #(
  parameter int unsigned FFT_SIZE       = 2048,
  parameter int unsigned CP_LEN1        = 160,
  parameter int unsigned CP_LEN2        = 144,
  parameter int unsigned LCP_SYM2       = 7,
  parameter int unsigned SYM_PER_SLOT   = 14,
  parameter int unsigned SLOT_PER_FRAME = 20,
  parameter int unsigned FRAME_WRAP     = 1024,
  parameter int unsigned N_CH           = 2,
  parameter int unsigned TRIG_LEN       = FFT_SIZE / 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pps_start,
  input  logic                 sync_enable,
  input  logic [31:0]          delay,
  input  logic [N_CH-1:0]      ch_en,
  input  logic [N_CH*16-1:0]   sym_mask,
  output logic [15:0]          sample_cnt,
  output logic [3:0]           symbol_cnt,
  output logic [7:0]           slot_cnt,
  output logic [9:0]           frame_cnt,
  output logic                 long_cp,
  output logic                 sym_start,
  output logic                 frame_start,
  output logic [N_CH-1:0]      trigger,
  output logic                 locked,
  output logic                 pps_err
);

  localparam logic [15:0] SLEN_LONG  = 16'(FFT_SIZE + CP_LEN1);
  localparam logic [15:0] SLEN_NORM  = 16'(FFT_SIZE + CP_LEN2);
  localparam logic [3:0]  LCP_IDX    = 4'(LCP_SYM2);
  localparam logic [3:0]  SYM_LAST   = 4'(SYM_PER_SLOT - 1);
  localparam logic [7:0]  SLOT_LAST  = 8'(SLOT_PER_FRAME - 1);
  localparam logic [9:0]  FRAME_LAST = 10'(FRAME_WRAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN} state_e;

  state_e      state_q;
  logic [31:0] time_cnt_q;
  logic        armed_q;
  logic [15:0] sample_q;
  logic [3:0]  symbol_q;
  logic [7:0]  slot_q;
  logic [9:0]  frame_q;
  logic        locked_q;
  logic        pps_err_q;

  logic        is_long;
  logic        wrap_sample;
  logic        wrap_sym;
  logic        wrap_slot;
  logic        align_evt;
  logic [15:0] sample_d;
  logic [3:0]  symbol_d;
  logic [7:0]  slot_d;
  logic [9:0]  frame_inc;
  logic [9:0]  frame_d;

  always_comb begin
    is_long     = (symbol_q == 4'd0) || (symbol_q == LCP_IDX);
    wrap_sample = sample_q == (is_long ? SLEN_LONG - 16'd1 : SLEN_NORM - 16'd1);
    wrap_sym    = wrap_sample && (symbol_q == SYM_LAST);
    wrap_slot   = wrap_sym && (slot_q == SLOT_LAST);
    align_evt   = armed_q && (time_cnt_q == delay) && (state_q != S_IDLE);
    frame_inc   = (frame_q == FRAME_LAST) ? '0 : frame_q + 10'd1;
    sample_d    = wrap_sample ? '0 : sample_q + 16'd1;
    symbol_d    = wrap_sample ? (wrap_sym ? '0 : symbol_q + 4'd1) : symbol_q;
    slot_d      = wrap_sym ? (wrap_slot ? '0 : slot_q + 8'd1) : slot_q;
    frame_d     = wrap_slot ? frame_inc : frame_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      time_cnt_q <= '0;
      armed_q    <= 1'b0;
      sample_q   <= '0;
      symbol_q   <= '0;
      slot_q     <= '0;
      frame_q    <= '0;
      locked_q   <= 1'b0;
      pps_err_q  <= 1'b0;
    end else if (!sync_enable) begin
      state_q    <= S_IDLE;
      time_cnt_q <= '0;
      armed_q    <= 1'b0;
      sample_q   <= '0;
      symbol_q   <= '0;
      slot_q     <= '0;
      frame_q    <= '0;
      locked_q   <= 1'b0;
      pps_err_q  <= 1'b0;
    end else begin
      pps_err_q <= 1'b0;
      // A PPS always (re)starts the delay count, even on the cycle an event fires.
      if (pps_start) begin
        armed_q    <= 1'b1;
        time_cnt_q <= '0;
      end else if (align_evt) begin
        armed_q    <= 1'b0;
      end else if (armed_q) begin
        time_cnt_q <= time_cnt_q + 32'd1;
      end

      case (state_q)
        S_IDLE: if (pps_start) state_q <= S_WAIT;
        S_WAIT: if (align_evt) state_q <= S_RUN;
        S_RUN: begin
          if (align_evt && !wrap_slot) begin
            sample_q  <= '0;
            symbol_q  <= '0;
            slot_q    <= '0;
            frame_q   <= frame_inc;
            locked_q  <= 1'b0;
            pps_err_q <= 1'b1;
          end else begin
            sample_q <= sample_d;
            symbol_q <= symbol_d;
            slot_q   <= slot_d;
            frame_q  <= frame_d;
            if (align_evt) locked_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic run;
  logic [15:0] ch_mask;

  always_comb begin
    run         = state_q == S_RUN;
    long_cp     = run && is_long;
    sym_start   = run && (sample_q == 16'd0);
    frame_start = sym_start && (symbol_q == 4'd0) && (slot_q == 8'd0);
    trigger     = '0;
    ch_mask     = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      ch_mask    = sym_mask[c*16 +: 16];
      trigger[c] = run && ch_en[c] && ch_mask[symbol_q] && (32'(sample_q) < TRIG_LEN);
    end
  end

  assign sample_cnt = sample_q;
  assign symbol_cnt = symbol_q;
  assign slot_cnt   = slot_q;
  assign frame_cnt  = frame_q;
  assign locked     = locked_q;
  assign pps_err    = pps_err_q;

endmodule

// File: tb/tb_frame_timing_gen.sv
// Directed bench for frame_timing_gen using a reduced numerology:
// long symbol 20 cycles, normal 18, slot 256, frame 512, frame_cnt wraps at 4.
module tb_frame_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pps_start = 1'b0;
  logic        sync_enable = 1'b0;
  logic [31:0] delay = '0;
  logic [1:0]  ch_en = '0;
  logic [31:0] sym_mask = '0;
  logic [15:0] sample_cnt;
  logic [3:0]  symbol_cnt;
  logic [7:0]  slot_cnt;
  logic [9:0]  frame_cnt;
  logic        long_cp, sym_start, frame_start, locked, pps_err;
  logic [1:0]  trigger;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int errs_seen = 0;
  int t0, t2, n, len;

  frame_timing_gen #(
    .FFT_SIZE(16), .CP_LEN1(4), .CP_LEN2(2), .LCP_SYM2(7), .SYM_PER_SLOT(14),
    .SLOT_PER_FRAME(2), .FRAME_WRAP(4), .N_CH(2), .TRIG_LEN(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pps_start(pps_start), .sync_enable(sync_enable),
    .delay(delay), .ch_en(ch_en), .sym_mask(sym_mask),
    .sample_cnt(sample_cnt), .symbol_cnt(symbol_cnt), .slot_cnt(slot_cnt),
    .frame_cnt(frame_cnt), .long_cp(long_cp), .sym_start(sym_start),
    .frame_start(frame_start), .trigger(trigger), .locked(locked), .pps_err(pps_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (pps_err) errs_seen <= errs_seen + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_pps();
    pps_start = 1'b1;
    tick();
    pps_start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    int g = 0;
    while (cyc < c && g < 5000) begin
      tick();
      g++;
    end
  endtask

  task automatic sym_len(output int l);
    l = 0;
    do begin
      tick();
      l++;
    end while (!sym_start && l < 100);
  endtask

  task automatic run_slot(input logic [1:0] en, input string tag);
    logic [15:0] m0;
    logic [15:0] m1;
    m0 = 16'h07FF;
    m1 = 16'h3000;
    ch_en = en;
    #1;
    for (int s = 0; s < 14; s++) begin
      int l = (s == 0 || s == 7) ? 20 : 18;
      for (int k = 0; k < l; k++) begin
        if (k == 0 || k == 7 || k == 8 || k == l - 1) begin
          logic [1:0] e;
          e[0] = en[0] && m0[s] && (k < 8);
          e[1] = en[1] && m1[s] && (k < 8);
          check_eq($sformatf("%s_trig_s%0d_k%0d", tag, s, k), 32'(trigger), 32'(e));
        end
        if (k == 0)
          check_eq($sformatf("%s_lcp_s%0d", tag, s), 32'(long_cp), 32'(s == 0 || s == 7));
        tick();
      end
    end
  endtask

  initial begin
    sym_mask = {16'h3000, 16'h07FF};
    #3;
    check_eq("reset_outputs",
             32'({sample_cnt, symbol_cnt, slot_cnt, frame_cnt, long_cp, sym_start,
                  frame_start, trigger, locked, pps_err}), 32'd0);
    tick();
    rst_n = 1'b1;
    sync_enable = 1'b1;
    repeat (5) tick();
    check_eq("idle_no_pps", 32'({sym_start, sample_cnt}), 32'd0);

    // First lock, delay 5
    delay = 32'd5;
    t0 = cyc;
    pulse_pps();
    n = 1;
    while (!frame_start && n < 50) begin
      tick();
      n++;
    end
    check_eq("first_lock_latency", 32'(n), 32'd7);
    check_eq("first_lock_locked", 32'(locked), 32'd0);
    check_eq("first_lock_lcp", 32'(long_cp), 32'd1);
    sym_len(len);
    check_eq("sym0_len", 32'(len), 32'd20);
    check_eq("sym1_idx", 32'(symbol_cnt), 32'd1);
    check_eq("sym1_lcp", 32'(long_cp), 32'd0);
    sym_len(len);
    check_eq("sym1_len", 32'(len), 32'd18);
    repeat (5) sym_len(len);
    check_eq("sym7_idx", 32'(symbol_cnt), 32'd7);
    check_eq("sym7_lcp", 32'(long_cp), 32'd1);
    sym_len(len);
    check_eq("sym7_len", 32'(len), 32'd20);

    // Aligned PPS one frame later
    wait_until(t0 + 512);
    pulse_pps();
    wait_until(t0 + 518);
    check_eq("aligned_last_pos", 32'({slot_cnt, symbol_cnt, sample_cnt}), 32'({8'd1, 4'd13, 16'd17}));
    check_eq("aligned_pre_locked", 32'(locked), 32'd0);
    tick();
    check_eq("aligned_frame_start", 32'(frame_start), 32'd1);
    check_eq("aligned_locked", 32'(locked), 32'd1);
    check_eq("aligned_frame_cnt", 32'(frame_cnt), 32'd1);
    check_eq("aligned_no_err", 32'(errs_seen), 32'd0);

    // Misaligned PPS, 3 cycles late
    t2 = t0 + 1027;
    wait_until(t2);
    pulse_pps();
    wait_until(t2 + 6);
    check_eq("mis_pre_state", 32'({locked, frame_cnt, sample_cnt}), 32'({1'b1, 10'd2, 16'd2}));
    tick();
    check_eq("mis_pps_err", 32'(pps_err), 32'd1);
    check_eq("mis_locked", 32'(locked), 32'd0);
    check_eq("mis_counters", 32'({slot_cnt, symbol_cnt, sample_cnt}), 32'd0);
    check_eq("mis_frame_cnt", 32'(frame_cnt), 32'd3);
    check_eq("mis_frame_start", 32'(frame_start), 32'd1);
    tick();
    check_eq("mis_err_one_cycle", 32'(pps_err), 32'd0);
    check_eq("mis_sample_run", 32'(sample_cnt), 32'd1);
    check_eq("mis_err_count", 32'(errs_seen), 32'd1);

    // Realigned PPS; frame_cnt wraps 3 -> 0
    wait_until(t2 + 512);
    pulse_pps();
    wait_until(t2 + 519);
    check_eq("relock_frame_start", 32'(frame_start), 32'd1);
    check_eq("relock_frame_wrap", 32'(frame_cnt), 32'd0);
    check_eq("relock_locked", 32'(locked), 32'd1);
    check_eq("relock_err_count", 32'(errs_seen), 32'd1);

    // Trigger masks over two slots
    run_slot(2'b11, "m11");
    run_slot(2'b01, "m01");

    // Disable mid-slot
    repeat (30) tick();
    check_eq("pre_dis_pos", 32'({locked, symbol_cnt, sample_cnt}), 32'({1'b1, 4'd1, 16'd10}));
    sync_enable = 1'b0;
    tick();
    check_eq("dis_counters",
             32'({sample_cnt, symbol_cnt, slot_cnt, frame_cnt}), 32'd0);
    check_eq("dis_flags", 32'({trigger, locked, sym_start, long_cp}), 32'd0);
    pulse_pps();
    repeat (3) tick();
    check_eq("dis_pps_ignored", 32'({sym_start, sample_cnt}), 32'd0);

    // Re-enable with delay 0
    sync_enable = 1'b1;
    delay = 32'd0;
    pulse_pps();
    n = 1;
    while (!frame_start && n < 50) begin
      tick();
      n++;
    end
    check_eq("delay0_latency", 32'(n), 32'd2);
    check_eq("delay0_locked", 32'(locked), 32'd0);

    // Asynchronous reset mid-run
    repeat (25) tick();
    check_eq("pre_rst_pos", 32'({symbol_cnt, sample_cnt, trigger}), 32'({4'd1, 16'd5, 2'b01}));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst",
             32'({sample_cnt, symbol_cnt, slot_cnt, trigger, sym_start, long_cp, locked}), 32'd0);
    #3;
    rst_n = 1'b1;
    repeat (5) tick();
    check_eq("post_rst_idle", 32'({sym_start, sample_cnt}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
